// File: rtl/buff_clock_pkg.sv
// Shared constants for the buff_clock local clock-root buffer.
`timescale 1ns/1ps
package buff_clock_pkg;

    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/buff_clock_clk_gate_cell.sv
// Integrated clock-gate equivalent: low-transparent latch followed by an AND.
// Kept as its own cell so a library ICG can be dropped in without touching the top.
`timescale 1ns/1ps
module clk_gate_cell (
    input  logic i_clk,
    input  logic i_en,
    output logic o_gclk,
    output logic o_gate
);

    logic r_gate;

    // Gate may only change while the clock is low, which rules out runt pulses.
    always_latch begin
        if (!i_clk) begin
            r_gate <= i_en;
        end
    end

    assign o_gclk = i_clk & r_gate;
    assign o_gate = r_gate;

endmodule

// File: rtl/buff_clock.sv
// Glitch-free gated clock buffer with synchronous enable/reset and a counter
// of buffered rising edges for monitoring.
`timescale 1ns/1ps
module buff_clock
    import buff_clock_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             buff_clk,
    output logic             active,
    output logic [CNT_W-1:0] edge_cnt
);

    logic             r_run;
    logic [CNT_W-1:0] r_edge_cnt;
    logic             w_gate;
    logic             w_gclk;

    // Enable register; reset dominates a simultaneous enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= en;
        end
    end

    clk_gate_cell u_gate (
        .i_clk  (clk),
        .i_en   (r_run),
        .o_gclk (w_gclk),
        .o_gate (w_gate)
    );

    // An open gate at a clk rising edge is exactly a buff_clk rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_edge_cnt <= '0;
        end else if (w_gate) begin
            r_edge_cnt <= r_edge_cnt + CNT_W'(1);
        end else begin
            r_edge_cnt <= r_edge_cnt;
        end
    end

    assign buff_clk = w_gclk;
    assign active   = w_gate;
    assign edge_cnt = r_edge_cnt;

endmodule

// File: tb/tb_buff_clock.sv
// Directed self-checking bench for buff_clock: reset, latency, alignment,
// pulse width, enable drop, reset mid-run and counter wrap (CNT_W=4 copy).
`timescale 1ns/1ps
module tb_buff_clock;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        buff_clk;
    logic        active;
    logic [15:0] edge_cnt;
    logic        buff_clk4;
    logic        active4;
    logic [3:0]  edge_cnt4;

    int unsigned n_cmp;
    int unsigned n_fail;

    // Monitor state for buff_clk edge timing
    logic   mon_en;
    int     rise_cnt;
    int     bad_align;
    int     bad_width;
    longint first_rise;
    longint last_rise;
    longint prev_rise;

    buff_clock #(.CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .buff_clk (buff_clk),
        .active   (active),
        .edge_cnt (edge_cnt)
    );

    buff_clock #(.CNT_W(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .buff_clk (buff_clk4),
        .active   (active4),
        .edge_cnt (edge_cnt4)
    );

    // 20 ns clock: rising edges at 10, 30, 50, ...
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Rising edges must land on clk rising edges (t = 10 mod 20).
    always @(posedge buff_clk) begin
        if (mon_en) begin
            if ((($time - 10) % 20) != 0 || clk !== 1'b1) bad_align = bad_align + 1;
            if (rise_cnt == 0) first_rise = $time;
            prev_rise = last_rise;
            last_rise = $time;
            rise_cnt  = rise_cnt + 1;
        end
    end

    // Falling edges must land on clk falling edges, and every pulse is 10 ns.
    always @(negedge buff_clk) begin
        if (mon_en && rise_cnt > 0) begin
            if (($time % 20) != 0 || clk !== 1'b0) bad_align = bad_align + 1;
            if (($time - last_rise) != 10) bad_width = bad_width + 1;
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic at(input longint t);
        #(t - $time);
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        mon_en     = 1'b0;
        rise_cnt   = 0;
        bad_align  = 0;
        bad_width  = 0;
        first_rise = 0;
        last_rise  = 0;
        prev_rise  = 0;
        rst_n      = 1'b0;
        en         = 1'b1;

        // Reset held over posedges 10/30/50 with en=1: everything stays low.
        at(21);
        chk("rst_buff_clk_a", buff_clk, 0);
        chk("rst_active_a",   active,   0);
        chk("rst_cnt_a",      edge_cnt, 0);
        at(41);
        chk("rst_buff_clk_b", buff_clk, 0);
        chk("rst_cnt4_b",     edge_cnt4, 0);
        at(51);
        chk("rst_buff_clk_c", buff_clk, 0);
        chk("rst_active_c",   active,   0);
        chk("rst_cnt_c",      edge_cnt, 0);

        // Release sampled at posedge 70 -> first buff_clk rise at 90.
        at(61);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        at(75);
        chk("rel_buff_clk_low", buff_clk, 0);
        chk("rel_active_low",   active,   0);
        at(85);
        chk("rel_active_open",  active,   1);

        // Ten buffered edges at 90..270.
        at(281);
        chk("first_rise_time", first_rise, 90);
        chk("cnt_after_10",    edge_cnt,   10);
        chk("period_ns",       last_rise - prev_rise, 20);
        chk("rise_cnt_10",     rise_cnt,   10);

        // Drop en while clk is high (after posedge 290): pulses at 290 and 310
        // complete, nothing afterwards.
        at(295);
        en = 1'b0;
        at(299);
        chk("drop_no_glitch", buff_clk, 1);
        at(315);
        chk("drop_last_pulse", buff_clk, 1);
        at(331);
        chk("drop_low",       buff_clk, 0);
        chk("drop_active",    active,   0);
        at(361);
        chk("drop_cnt_frozen", edge_cnt, 12);
        chk("drop_buff_low",   buff_clk, 0);

        // Restart: en sampled at 370, edges at 390..470 -> count 17, 4-bit wraps to 1.
        en = 1'b1;
        at(475);
        chk("cnt_17",    edge_cnt,  17);
        chk("cnt4_wrap", edge_cnt4, 1);

        // Reset while running: posedge 490 clears counter, its pulse still completes.
        rst_n = 1'b0;
        at(491);
        chk("rst_run_cnt",     edge_cnt, 0);
        chk("rst_run_pulse",   buff_clk, 1);
        at(501);
        chk("rst_run_closed",  buff_clk, 0);
        chk("rst_run_active",  active,   0);

        // Reset with en=1 keeps gate closed.
        at(541);
        chk("rst_wins_active", active,   0);
        chk("rst_wins_cnt",    edge_cnt, 0);
        chk("rst_wins_cnt4",   edge_cnt4, 0);

        // Edge-level monitoring over the whole run.
        chk("total_rises", rise_cnt,  18);
        chk("bad_align",   bad_align, 0);
        chk("bad_width",   bad_width, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
